// File: rtl/alu_pkg.sv
// Shared encodings for the accumulator ALU and its command sequencer.
package alu_pkg;

  typedef enum logic [1:0] {
    S_off       = 2'b00,
    S_ready     = 2'b01,
    S_run       = 2'b10,
    S_run_error = 2'b11
  } alu_state_e;

  localparam logic [2:0] IN_PERSIST = 3'b100;
  localparam logic [2:0] IN_LOAD    = 3'b010;
  localparam logic [2:0] IN_RESET   = 3'b001;

  localparam logic [6:0] OUT_NONE = 7'b0000000;
  localparam logic [6:0] OUT_AND  = 7'b0000001;
  localparam logic [6:0] OUT_OR   = 7'b0000010;
  localparam logic [6:0] OUT_XOR  = 7'b0000100;
  localparam logic [6:0] OUT_NOT  = 7'b0001000;
  localparam logic [6:0] OUT_ADD  = 7'b0010000;
  localparam logic [6:0] OUT_SUB  = 7'b0100000;
  localparam logic [6:0] OUT_MULT = 7'b1000000;

  localparam logic [2:0] OP_AND  = 3'd0;
  localparam logic [2:0] OP_OR   = 3'd1;
  localparam logic [2:0] OP_XOR  = 3'd2;
  localparam logic [2:0] OP_NOT  = 3'd3;
  localparam logic [2:0] OP_ADD  = 3'd4;
  localparam logic [2:0] OP_SUB  = 3'd5;
  localparam logic [2:0] OP_MULT = 3'd6;
  localparam logic [2:0] OP_CLR  = 3'd7;

  typedef enum logic [2:0] {
    ST_INIT  = 3'd0,
    ST_IDLE  = 3'd1,
    ST_ISSUE = 3'd2,
    ST_EXEC  = 3'd3,
    ST_RESP  = 3'd4
  } seq_state_e;

endpackage

// File: rtl/alu_op_decode.sv
// Maps a sequencer opcode to the ALU one-hot output select; CLR selects nothing.
module alu_op_decode
  import alu_pkg::*;
(
  input  logic [2:0] op,
  output logic [6:0] out_sel
);

  // opcode to one-hot output select
  always_comb begin
    case (op)
      OP_AND:  out_sel = OUT_AND;
      OP_OR:   out_sel = OUT_OR;
      OP_XOR:  out_sel = OUT_XOR;
      OP_NOT:  out_sel = OUT_NOT;
      OP_ADD:  out_sel = OUT_ADD;
      OP_SUB:  out_sel = OUT_SUB;
      OP_MULT: out_sel = OUT_MULT;
      default: out_sel = OUT_NONE;
    endcase
  end

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Command front-end for the accumulator ALU: accepts commands, sequences the
// ALU load/execute cycles and returns result plus error over a response handshake.
module alu_cmd_sequencer
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic             cmd_chain,
  input  logic [WIDTH-1:0] cmd_a,
  input  logic [WIDTH-1:0] cmd_b,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_err,
  output logic             alu_on,
  output logic [2:0]       alu_in_sel,
  output logic [WIDTH-1:0] alu_num1,
  output logic [WIDTH-1:0] alu_num2,
  output logic [6:0]       alu_out_sel,
  input  logic [WIDTH-1:0] alu_result,
  input  logic [1:0]       alu_next
);

  seq_state_e       state_q, state_d;
  logic [2:0]       op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic             rsp_err_q, rsp_err_d;
  logic [6:0]       dec_out_sel;

  alu_op_decode u_op_decode (
    .op      (op_q),
    .out_sel (dec_out_sel)
  );

  // next-state and datapath register updates
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    a_d        = a_q;
    b_d        = b_q;
    acc_d      = acc_q;
    rsp_data_d = rsp_data_q;
    rsp_err_d  = rsp_err_q;
    case (state_q)
      ST_INIT: state_d = ST_IDLE;
      ST_IDLE: begin
        if (cmd_valid) begin
          op_d    = cmd_op;
          a_d     = cmd_chain ? acc_q : cmd_a;
          b_d     = cmd_b;
          state_d = ST_ISSUE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        if (op_q == OP_CLR) begin
          acc_d      = '0;
          rsp_data_d = '0;
          rsp_err_d  = 1'b0;
          state_d    = ST_RESP;
        end else begin
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        // the error is reported but the accumulator still takes the result
        rsp_data_d = alu_result;
        acc_d      = alu_result;
        rsp_err_d  = (alu_next == S_run_error);
        state_d    = ST_RESP;
      end
      ST_RESP: begin
        if (rsp_ready) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_RESP;
        end
      end
      default: state_d = ST_INIT;
    endcase
  end

  // state and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_INIT;
      op_q       <= 3'd0;
      a_q        <= '0;
      b_q        <= '0;
      acc_q      <= '0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      a_q        <= a_d;
      b_q        <= b_d;
      acc_q      <= acc_d;
      rsp_data_q <= rsp_data_d;
      rsp_err_q  <= rsp_err_d;
    end
  end

  // handshake and ALU control decode from state and latched command
  always_comb begin
    cmd_ready   = 1'b0;
    rsp_valid   = 1'b0;
    alu_on      = 1'b1;
    alu_in_sel  = IN_LOAD;
    alu_out_sel = OUT_NONE;
    case (state_q)
      ST_INIT: begin
        // keeps the ALU off while reset is still asserted
        alu_on     = rst_n;
        alu_in_sel = IN_RESET;
      end
      ST_IDLE:  cmd_ready = 1'b1;
      ST_ISSUE: alu_in_sel = (op_q == OP_CLR) ? IN_RESET : IN_LOAD;
      ST_EXEC:  alu_out_sel = dec_out_sel;
      ST_RESP:  rsp_valid = 1'b1;
      default: begin
        alu_on     = 1'b0;
        alu_in_sel = IN_RESET;
      end
    endcase
  end

  assign alu_num1 = a_q;
  assign alu_num2 = b_q;
  assign rsp_data = rsp_data_q;
  assign rsp_err  = rsp_err_q;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Directed bench for alu_cmd_sequencer with a behavioural ALU and a response scoreboard.
module tb_alu_cmd_sequencer;
  import alu_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [2:0] cmd_op = 3'd0;
  logic       cmd_chain = 1'b0;
  logic [7:0] cmd_a = 8'h00;
  logic [7:0] cmd_b = 8'h00;
  logic       rsp_valid;
  logic       rsp_ready = 1'b1;
  logic [7:0] rsp_data;
  logic       rsp_err;
  logic       alu_on;
  logic [2:0] alu_in_sel;
  logic [7:0] alu_num1, alu_num2;
  logic [6:0] alu_out_sel;
  logic [7:0] alu_result;
  logic [1:0] alu_next;

  int n_checks = 0;
  int n_fail = 0;
  logic [8:0] exp_q[$];

  always #5 clk = ~clk;

  alu_cmd_sequencer #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_chain(cmd_chain), .cmd_a(cmd_a), .cmd_b(cmd_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .alu_on(alu_on), .alu_in_sel(alu_in_sel), .alu_num1(alu_num1), .alu_num2(alu_num2),
    .alu_out_sel(alu_out_sel), .alu_result(alu_result), .alu_next(alu_next)
  );

  // Behavioural ALU: operand flops load on 010, clear on 001; MULT overflow flags run_error.
  logic [7:0]  m1_q, m2_q;
  logic [15:0] prod;
  always @(posedge clk) begin
    if (alu_on && alu_in_sel == 3'b001) begin
      m1_q <= 8'h00;
      m2_q <= 8'h00;
    end else if (alu_on && alu_in_sel == 3'b010) begin
      m1_q <= alu_num1;
      m2_q <= alu_num2;
    end
  end

  always_comb begin
    prod       = 16'(m1_q) * 16'(m2_q);
    alu_result = 8'h00;
    alu_next   = alu_on ? 2'b01 : 2'b00;
    case (alu_out_sel)
      7'b0000001: begin alu_result = m1_q & m2_q; alu_next = 2'b10; end
      7'b0000010: begin alu_result = m1_q | m2_q; alu_next = 2'b10; end
      7'b0000100: begin alu_result = m1_q ^ m2_q; alu_next = 2'b10; end
      7'b0001000: begin alu_result = ~m1_q;       alu_next = 2'b10; end
      7'b0010000: begin alu_result = m1_q + m2_q; alu_next = 2'b10; end
      7'b0100000: begin alu_result = m1_q - m2_q; alu_next = 2'b10; end
      7'b1000000: begin
        alu_result = prod[7:0];
        alu_next   = (prod > 16'h00FF) ? 2'b11 : 2'b10;
      end
      default: ;
    endcase
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: each completed response handshake is compared with the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && rsp_valid && rsp_ready) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL rsp_unexpected: got data=%0h err=%0b with nothing expected", rsp_data, rsp_err);
      end else begin
        logic [8:0] e;
        e = exp_q.pop_front();
        if ({rsp_err, rsp_data} !== e) begin
          n_fail++;
          $display("FAIL rsp_data_err: got err=%0b data=%0h expected err=%0b data=%0h",
                   rsp_err, rsp_data, e[8], e[7:0]);
        end
      end
    end
  end

  function automatic logic [6:0] onehot(input logic [2:0] op);
    logic [6:0] r;
    r = 7'b0000001;
    return (op == OP_CLR) ? 7'b0000000 : 7'(r << op);
  endfunction

  task automatic wait_ready();
    int t;
    t = 0;
    while (!cmd_ready && t < 20) begin
      @(posedge clk); #1;
      t++;
    end
    chk("cmd_ready_wait", {31'd0, cmd_ready}, 32'd1);
  endtask

  task automatic run_cmd(input logic [2:0] op, input logic ch, input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] exp_n1, input logic [7:0] exp_d, input logic exp_e,
                         input int stall);
    wait_ready();
    exp_q.push_back({exp_e, exp_d});
    rsp_ready = (stall == 0);
    cmd_valid = 1'b1; cmd_op = op; cmd_chain = ch; cmd_a = a; cmd_b = b;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    chk("issue_num1", 32'(alu_num1), 32'(exp_n1));
    chk("issue_num2", 32'(alu_num2), 32'(b));
    chk("issue_in_sel", 32'(alu_in_sel), (op == OP_CLR) ? 32'd1 : 32'd2);
    if (op != OP_CLR) begin
      @(posedge clk); #1;
      chk("exec_out_sel", 32'(alu_out_sel), 32'(onehot(op)));
      chk("exec_in_sel", 32'(alu_in_sel), 32'd2);
    end
    @(posedge clk); #1;
    chk("rsp_valid_latency", {31'd0, rsp_valid}, 32'd1);
    for (int i = 0; i < stall; i++) begin
      chk("stall_rsp_valid", {31'd0, rsp_valid}, 32'd1);
      chk("stall_rsp_data", 32'(rsp_data), 32'(exp_d));
      chk("stall_rsp_err", {31'd0, rsp_err}, {31'd0, exp_e});
      chk("stall_cmd_ready", {31'd0, cmd_ready}, 32'd0);
      cmd_valid = 1'b1; cmd_op = OP_ADD; cmd_chain = 1'b0; cmd_a = 8'hAA; cmd_b = 8'h55;
      @(posedge clk); #1;
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    chk("back_to_idle", {31'd0, cmd_ready}, 32'd1);
    chk("rsp_valid_drop", {31'd0, rsp_valid}, 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_cmd_ready"}, {31'd0, cmd_ready}, 32'd0);
    chk({tag, "_rsp_valid"}, {31'd0, rsp_valid}, 32'd0);
    chk({tag, "_rsp_data"}, 32'(rsp_data), 32'd0);
    chk({tag, "_rsp_err"}, {31'd0, rsp_err}, 32'd0);
    chk({tag, "_alu_on"}, {31'd0, alu_on}, 32'd0);
    chk({tag, "_in_sel"}, 32'(alu_in_sel), 32'd1);
    chk({tag, "_num1"}, 32'(alu_num1), 32'd0);
    chk({tag, "_num2"}, 32'(alu_num2), 32'd0);
    chk({tag, "_out_sel"}, 32'(alu_out_sel), 32'd0);
  endtask

  task automatic release_and_check_init();
    rst_n = 1'b1;
    #1;
    chk("init_alu_on", {31'd0, alu_on}, 32'd1);
    chk("init_in_sel", 32'(alu_in_sel), 32'd1);
    chk("init_cmd_ready", {31'd0, cmd_ready}, 32'd0);
    @(posedge clk); #1;
    chk("idle_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    chk("idle_in_sel", 32'(alu_in_sel), 32'd2);
    chk("idle_out_sel", 32'(alu_out_sel), 32'd0);
  endtask

  initial begin
    #10000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    release_and_check_init();

    run_cmd(OP_ADD,  1'b0, 8'h05, 8'h03, 8'h05, 8'h08, 1'b0, 0);
    run_cmd(OP_ADD,  1'b0, 8'h02, 8'h03, 8'h02, 8'h05, 1'b0, 0);
    run_cmd(OP_MULT, 1'b1, 8'hEE, 8'h04, 8'h05, 8'h14, 1'b0, 0);
    run_cmd(OP_MULT, 1'b0, 8'h10, 8'h10, 8'h10, 8'h00, 1'b1, 0);
    run_cmd(OP_ADD,  1'b1, 8'hEE, 8'h01, 8'h00, 8'h01, 1'b0, 0);
    run_cmd(OP_ADD,  1'b0, 8'h01, 8'h01, 8'h01, 8'h02, 1'b0, 0);
    run_cmd(OP_AND,  1'b0, 8'hF0, 8'h3C, 8'hF0, 8'h30, 1'b0, 0);
    run_cmd(OP_OR,   1'b0, 8'hF0, 8'h3C, 8'hF0, 8'hFC, 1'b0, 0);
    run_cmd(OP_NOT,  1'b0, 8'h0F, 8'h99, 8'h0F, 8'hF0, 1'b0, 0);
    run_cmd(OP_SUB,  1'b1, 8'h00, 8'h03, 8'hF0, 8'hED, 1'b0, 0);
    run_cmd(OP_XOR,  1'b0, 8'hF0, 8'h3C, 8'hF0, 8'hCC, 1'b0, 5);
    run_cmd(OP_CLR,  1'b0, 8'h55, 8'h66, 8'h55, 8'h00, 1'b0, 0);
    run_cmd(OP_ADD,  1'b1, 8'hEE, 8'h07, 8'h00, 8'h07, 1'b0, 0);

    // Reset pulsed during EXEC: the in-flight response must vanish.
    wait_ready();
    cmd_valid = 1'b1; cmd_op = OP_ADD; cmd_chain = 1'b0; cmd_a = 8'h11; cmd_b = 8'h22;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    @(posedge clk); #1;
    chk("pre_abort_out_sel", 32'(alu_out_sel), 32'h10);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("abort");
    @(posedge clk); @(posedge clk); #1;
    release_and_check_init();
    repeat (4) begin
      @(posedge clk); #1;
      chk("abort_no_rsp", {31'd0, rsp_valid}, 32'd0);
    end
    run_cmd(OP_ADD, 1'b1, 8'hEE, 8'h02, 8'h00, 8'h02, 1'b0, 0);

    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule
